apb_slave_fsm: RTL and testbench
================================

// Module: apb_slave_fsm
// PURPOSE
//  APB3 slave front end for the matrix-multiplier register map; sits directly upstream of the address decoder.
//  Captures each APB transfer in its setup phase and holds reg_addr_o stable for the decoder.
//  Issues a single-cycle write/read strobe to the selected register bank, then returns prdata/pslverr with pready.
//  Supports programmable wait states and flags protocol violations.
// PARAMETERS
//  DATA_WIDTH   32  APB data width (multiple of 8)
//  ADDR_WIDTH   3   register-select address width forwarded to the decoder
//  WAIT_CYCLES  1   extra wait states before the strobe (0..15); counter width $clog2(WAIT_CYCLES+1), min 1
// PORTS
//  clk_i        in   1             clock; all logic on the rising edge
//  rst_i        in   1             synchronous reset, active-high
//  psel_i       in   1             APB select
//  penable_i    in   1             APB enable (access phase)
//  pwrite_i     in   1             1 = write, 0 = read
//  paddr_i      in   ADDR_WIDTH    APB address
//  pwdata_i     in   DATA_WIDTH    APB write data
//  pstrb_i      in   DATA_WIDTH/8  APB byte strobes
//  pready_o     out  1             transfer complete
//  prdata_o     out  DATA_WIDTH    read data; valid when pready_o=1 on a read
//  pslverr_o    out  1             slave error; valid when pready_o=1
//  reg_addr_o   out  ADDR_WIDTH    captured address to the decoder
//  reg_wdata_o  out  DATA_WIDTH    captured write data
//  reg_wstrb_o  out  DATA_WIDTH/8  captured byte strobes
//  reg_wr_o     out  1             one-cycle write strobe
//  reg_rd_o     out  1             one-cycle read strobe
//  reg_rdata_i  in   DATA_WIDTH    read data from the bank; combinational, valid in the reg_rd_o cycle
//  reg_err_i    in   1             bank error; sampled in the strobe cycle
//  busy_o       out  1             state != IDLE
//  proto_err_o  out  1             one-cycle pulse on an APB protocol violation
// BEHAVIOUR
//  - Reset: state IDLE, counter 0, all captured registers 0, all outputs 0.
//    reg_wr_o/reg_rd_o are forced to 0 in any cycle with rst_i=1; reset takes priority over every other event.
//  - States IDLE, WAIT, STROBE, RESP (Moore).
//    pready_o = (RESP); reg_wr_o = STROBE & wr_q; reg_rd_o = STROBE & !wr_q.
//  - IDLE, psel_i=1 & penable_i=0 (setup phase):
//    capture paddr, pwdata, pstrb, pwrite; cnt <= WAIT_CYCLES; go to WAIT.
//  - IDLE, psel_i=1 & penable_i=1 (no setup phase): transfer ignored; proto_err_o pulses next cycle; stay in IDLE.
//  - WAIT: if cnt==0, go to STROBE; else cnt <= cnt-1.
//  - STROBE: exactly one strobe cycle. Capture prdata_q <= reg_rdata_i (reads only) and err_q <= reg_err_i.
//    Then go to RESP.
//  - RESP: pready_o=1, prdata_o=prdata_q (reads; 0 for writes), pslverr_o=err_q. Then go to IDLE.
//  - Outside RESP: prdata_o=0, pslverr_o=0.
//  - Latency from the setup cycle (cycle 0): strobe at cycle 2+WAIT_CYCLES; pready at cycle 3+WAIT_CYCLES.
//  - Abort: psel_i=0 or penable_i=0 in WAIT or STROBE. Go to IDLE next cycle; proto_err_o pulses that next cycle.
//    Abort in WAIT: no strobe is issued.
//    Abort in STROBE: the strobe in that cycle still fires; RESP is skipped.
//  - RESP ignores psel_i/penable_i.
//  - Back-to-back: a setup phase in the cycle after RESP is accepted (IDLE).
//    No idle gap is required beyond that single cycle.
//  - reg_addr_o, reg_wdata_o, reg_wstrb_o change only on capture.
//    They stay stable from cycle 1 until the next transfer's capture.
//    Changes to paddr_i/pwdata_i after the setup cycle have no effect.
//  - busy_o=1 in WAIT, STROBE, RESP.
// TESTING
//  1. rst_i=1 for 2 cycles while psel_i=1, penable_i=1 -> all outputs 0, busy_o=0, no strobe, no proto_err_o.
//  2. WAIT_CYCLES=1; write paddr=3'b001, pwdata=32'hDEADBEEF, pstrb=4'hF, setup at cycle 0 ->
//     reg_addr_o=001 from cycle 1; reg_wr_o=1 only at cycle 3; pready_o=1 at cycle 4; pslverr_o=0.
//  3. WAIT_CYCLES=0; read paddr=3'b011, reg_rdata_i=32'h12345678 ->
//     reg_rd_o=1 at cycle 2; pready_o=1 and prdata_o=32'h12345678 at cycle 3.
//  4. Read with reg_err_i=1 in the strobe cycle -> pslverr_o=1 with pready_o; next transfer has pslverr_o=0.
//  5. WAIT_CYCLES=2; psel_i dropped at cycle 2 (WAIT) -> no reg_wr_o/reg_rd_o ever; proto_err_o=1 at cycle 3; busy_o=0 at cycle 3.
//  6. Write to 3'b100 then read from 3'b010, second setup in the cycle after the first RESP ->
//     exactly one reg_wr_o and one reg_rd_o; reg_addr_o switches 100 -> 010 at the second capture; two pready_o pulses.

Source files
------------

// File: rtl/apb_slave_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// apb_slave_fsm : APB3 slave front end - capture, wait states, strobe, respond
// Rev 1.0
// ----------------------------------------------------------------------------
module apb_slave_fsm #(
   parameter int DATA_WIDTH  = 32,
   parameter int ADDR_WIDTH  = 3,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    psel_i,
   input  logic                    penable_i,
   input  logic                    pwrite_i,
   input  logic [ADDR_WIDTH-1:0]   paddr_i,
   input  logic [DATA_WIDTH-1:0]   pwdata_i,
   input  logic [DATA_WIDTH/8-1:0] pstrb_i,
   output logic                    pready_o,
   output logic [DATA_WIDTH-1:0]   prdata_o,
   output logic                    pslverr_o,
   output logic [ADDR_WIDTH-1:0]   reg_addr_o,
   output logic [DATA_WIDTH-1:0]   reg_wdata_o,
   output logic [DATA_WIDTH/8-1:0] reg_wstrb_o,
   output logic                    reg_wr_o,
   output logic                    reg_rd_o,
   input  logic [DATA_WIDTH-1:0]   reg_rdata_i,
   input  logic                    reg_err_i,
   output logic                    busy_o,
   output logic                    proto_err_o
);

   localparam int CNT_WIDTH = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_WAIT   = 2'd1,
      ST_STROBE = 2'd2,
      ST_RESP   = 2'd3
   } state_t;

   state_t                    state;
   logic [CNT_WIDTH-1:0]      cnt;
   logic                      wr_q;
   logic [ADDR_WIDTH-1:0]     addr_q;
   logic [DATA_WIDTH-1:0]     wdata_q;
   logic [DATA_WIDTH/8-1:0]   strb_q;
   logic                      wr_stb_q;
   logic                      rd_stb_q;
   logic                      pready_q;
   logic [DATA_WIDTH-1:0]     prdata_q;
   logic                      err_q;
   logic                      proto_err_q;
   logic                      access_ok;

   assign access_ok = psel_i & penable_i;

   // Outputs are registered alongside the state so each is valid exactly in its Moore state.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         strb_q      <= '0;
         wr_stb_q    <= 1'b0;
         rd_stb_q    <= 1'b0;
         pready_q    <= 1'b0;
         prdata_q    <= '0;
         err_q       <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         wr_stb_q    <= 1'b0;
         rd_stb_q    <= 1'b0;
         pready_q    <= 1'b0;
         prdata_q    <= '0;
         err_q       <= 1'b0;
         proto_err_q <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (psel_i && !penable_i) begin
                  addr_q  <= paddr_i;
                  wdata_q <= pwdata_i;
                  strb_q  <= pstrb_i;
                  wr_q    <= pwrite_i;
                  cnt     <= CNT_WIDTH'(WAIT_CYCLES);
                  state   <= ST_WAIT;
               end else if (psel_i && penable_i) begin
                  proto_err_q <= 1'b1;
               end
            end
            ST_WAIT: begin
               if (!access_ok) begin
                  proto_err_q <= 1'b1;
                  state       <= ST_IDLE;
               end else if (cnt == '0) begin
                  wr_stb_q <= wr_q;
                  rd_stb_q <= !wr_q;
                  state    <= ST_STROBE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            ST_STROBE: begin
               // The strobe for this cycle has already been issued; an abort only drops the response.
               if (!access_ok) begin
                  proto_err_q <= 1'b1;
                  state       <= ST_IDLE;
               end else begin
                  pready_q <= 1'b1;
                  prdata_q <= wr_q ? '0 : reg_rdata_i;
                  err_q    <= reg_err_i;
                  state    <= ST_RESP;
               end
            end
            ST_RESP: begin
               state <= ST_IDLE;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign pready_o    = pready_q;
   assign prdata_o    = prdata_q;
   assign pslverr_o   = err_q;
   assign reg_addr_o  = addr_q;
   assign reg_wdata_o = wdata_q;
   assign reg_wstrb_o = strb_q;
   assign reg_wr_o    = wr_stb_q & ~rst_i;
   assign reg_rd_o    = rd_stb_q & ~rst_i;
   assign busy_o      = (state != ST_IDLE);
   assign proto_err_o = proto_err_q;

endmodule
`default_nettype wire

// File: tb/tb_apb_slave_fsm.sv
`default_nettype none
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// tb_apb_slave_fsm : scoreboard bench over three wait-state configurations
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_apb_slave_fsm;

   localparam logic [3:0] K_WR   = 4'b0001;
   localparam logic [3:0] K_RD   = 4'b0010;
   localparam logic [3:0] K_RDY  = 4'b0100;
   localparam logic [3:0] K_PERR = 4'b1000;

   typedef struct {
      logic [3:0]  kind;
      int          cyc;
      logic [2:0]  addr;
      logic [31:0] data;
      logic [3:0]  strb;
      logic        err;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        psel, penable, pwrite;
   logic [2:0]  paddr;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic [31:0] reg_rdata;
   logic        reg_err;

   logic [2:0]  pready_a, pslverr_a, wr_a, rd_a, busy_a, perr_a;
   logic [31:0] prdata_a [3];
   logic [31:0] wdata_a  [3];
   logic [2:0]  addr_a   [3];
   logic [3:0]  strb_a   [3];

   int   cyc    = 0;
   int   sel    = 1;   // DUT under observation; index equals its WAIT_CYCLES
   int   checks = 0;
   int   errors = 0;
   ev_t  q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   apb_slave_fsm #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .WAIT_CYCLES(0)) u_w0 (
      .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
      .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
      .pready_o(pready_a[0]), .prdata_o(prdata_a[0]), .pslverr_o(pslverr_a[0]),
      .reg_addr_o(addr_a[0]), .reg_wdata_o(wdata_a[0]), .reg_wstrb_o(strb_a[0]),
      .reg_wr_o(wr_a[0]), .reg_rd_o(rd_a[0]), .reg_rdata_i(reg_rdata), .reg_err_i(reg_err),
      .busy_o(busy_a[0]), .proto_err_o(perr_a[0]));

   apb_slave_fsm #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .WAIT_CYCLES(1)) u_w1 (
      .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
      .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
      .pready_o(pready_a[1]), .prdata_o(prdata_a[1]), .pslverr_o(pslverr_a[1]),
      .reg_addr_o(addr_a[1]), .reg_wdata_o(wdata_a[1]), .reg_wstrb_o(strb_a[1]),
      .reg_wr_o(wr_a[1]), .reg_rd_o(rd_a[1]), .reg_rdata_i(reg_rdata), .reg_err_i(reg_err),
      .busy_o(busy_a[1]), .proto_err_o(perr_a[1]));

   apb_slave_fsm #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .WAIT_CYCLES(2)) u_w2 (
      .clk_i(clk), .rst_i(rst), .psel_i(psel), .penable_i(penable), .pwrite_i(pwrite),
      .paddr_i(paddr), .pwdata_i(pwdata), .pstrb_i(pstrb),
      .pready_o(pready_a[2]), .prdata_o(prdata_a[2]), .pslverr_o(pslverr_a[2]),
      .reg_addr_o(addr_a[2]), .reg_wdata_o(wdata_a[2]), .reg_wstrb_o(strb_a[2]),
      .reg_wr_o(wr_a[2]), .reg_rd_o(rd_a[2]), .reg_rdata_i(reg_rdata), .reg_err_i(reg_err),
      .busy_o(busy_a[2]), .proto_err_o(perr_a[2]));

   function automatic void push(input logic [3:0] kind, input int c, input logic [2:0] a,
                                input logic [31:0] d, input logic [3:0] s, input logic e);
      ev_t ev;
      ev.kind = kind; ev.cyc = c; ev.addr = a; ev.data = d; ev.strb = s; ev.err = e;
      q.push_back(ev);
   endfunction

   // Monitor: every strobe, pready or proto_err pulse of the observed DUT consumes one expectation.
   logic [3:0] m_flags;
   ev_t        m_ev;
   bit         m_ok;
   always @(posedge clk) begin
      #1;
      m_flags = {perr_a[sel], pready_a[sel], rd_a[sel], wr_a[sel]};
      if (m_flags != 4'b0000) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event dut=w%0d cyc=%0d kind=%b, required no event", sel, cyc, m_flags);
         end else begin
            m_ev = q.pop_front();
            m_ok = (m_flags == m_ev.kind) && (cyc == m_ev.cyc);
            case (m_ev.kind)
               K_WR:    m_ok = m_ok && addr_a[sel] == m_ev.addr && wdata_a[sel] == m_ev.data
                                    && strb_a[sel] == m_ev.strb;
               K_RD:    m_ok = m_ok && addr_a[sel] == m_ev.addr;
               K_RDY:   m_ok = m_ok && prdata_a[sel] == m_ev.data && pslverr_a[sel] == m_ev.err;
               default: m_ok = m_ok && busy_a[sel] == 1'b0;
            endcase
            if (!m_ok)
               $display("FAIL event dut=w%0d got cyc=%0d kind=%b addr=%b wdata=%h strb=%h prdata=%h err=%b busy=%b; required cyc=%0d kind=%b addr=%b data=%h strb=%h err=%b",
                        sel, cyc, m_flags, addr_a[sel], wdata_a[sel], strb_a[sel], prdata_a[sel],
                        pslverr_a[sel], busy_a[sel], m_ev.cyc, m_ev.kind, m_ev.addr, m_ev.data,
                        m_ev.strb, m_ev.err);
            if (!m_ok) errors++;
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Full transfer starting at a negedge; ends at the negedge of the cycle after RESP.
   task automatic xfer(input bit wr, input logic [2:0] a, input logic [31:0] d, input logic [3:0] s,
                       input logic [31:0] rdv, input bit err);
      int c0;
      int n;
      c0 = cyc;
      psel = 1'b1; penable = 1'b0; pwrite = wr; paddr = a; pwdata = d; pstrb = s;
      reg_rdata = rdv; reg_err = err;
      push(wr ? K_WR : K_RD, c0 + 2 + sel, a, d, s, 1'b0);
      push(K_RDY, c0 + 3 + sel, 3'b000, wr ? 32'h0 : rdv, 4'h0, err);
      @(negedge clk);
      penable = 1'b1; paddr = ~a; pwdata = ~d; pstrb = ~s;
      checks++;
      if (addr_a[sel] != a || wdata_a[sel] != d || strb_a[sel] != s) begin
         errors++;
         $display("FAIL capture dut=w%0d cyc=%0d got addr=%b wdata=%h strb=%h, required addr=%b wdata=%h strb=%h",
                  sel, cyc, addr_a[sel], wdata_a[sel], strb_a[sel], a, d, s);
      end
      n = 0;
      while (!pready_a[sel] && n < 40) begin
         @(negedge clk);
         n++;
      end
      if (!pready_a[sel]) begin
         checks++;
         errors++;
         $display("FAIL pready_timeout dut=w%0d got pready=0, required pready=1 within 40 cycles", sel);
      end
      @(negedge clk);
      psel = 1'b0; penable = 1'b0; reg_err = 1'b0;
   endtask

   // Transfer whose psel/penable are dropped in cycle 2 after setup.
   task automatic abort_xfer(input bit strobe_fires, input logic [2:0] a, input logic [31:0] d);
      int c0;
      c0 = cyc;
      psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = 4'hF;
      if (strobe_fires) push(K_WR, c0 + 2, a, d, 4'hF, 1'b0);
      push(K_PERR, c0 + 3, 3'b000, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      penable = 1'b1;
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
      idle(4);
   endtask

   task automatic idle_violation();
      psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 3'b111;
      push(K_PERR, cyc + 1, 3'b000, 32'h0, 4'h0, 1'b0);
      @(negedge clk);
      psel = 1'b0; penable = 1'b0;
      idle(3);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, required completion within 100us");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 3'b101;
      pwdata = 32'hFFFF_FFFF; pstrb = 4'hF; reg_rdata = 32'h0; reg_err = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
         checks++;
         if ({pready_a[k], pslverr_a[k], wr_a[k], rd_a[k], busy_a[k], perr_a[k]} != 6'b0 ||
             prdata_a[k] != 32'h0 || wdata_a[k] != 32'h0 || addr_a[k] != 3'b0 || strb_a[k] != 4'h0) begin
            errors++;
            $display("FAIL reset dut=w%0d got rdy=%b err=%b wr=%b rd=%b busy=%b perr=%b prdata=%h addr=%b, required all 0",
                     k, pready_a[k], pslverr_a[k], wr_a[k], rd_a[k], busy_a[k], perr_a[k], prdata_a[k], addr_a[k]);
         end
      end
      rst = 1'b0; psel = 1'b0; penable = 1'b0;
      idle(2);

      sel = 1;
      xfer(1'b1, 3'b001, 32'hDEAD_BEEF, 4'hF, 32'h0, 1'b0);
      idle(2);

      sel = 0;
      xfer(1'b0, 3'b011, 32'h0, 4'h0, 32'h1234_5678, 1'b0);
      idle(2);
      xfer(1'b0, 3'b101, 32'h0, 4'h0, 32'hCAFE_F00D, 1'b1);
      xfer(1'b1, 3'b110, 32'h0BAD_F00D, 4'h5, 32'h0, 1'b0);
      idle(2);

      sel = 2;
      abort_xfer(1'b0, 3'b010, 32'h1111_2222);
      xfer(1'b1, 3'b111, 32'h0000_A5A5, 4'h3, 32'h0, 1'b0);
      idle(3);

      sel = 0;
      abort_xfer(1'b1, 3'b100, 32'h3333_4444);

      sel = 1;
      idle_violation();
      xfer(1'b1, 3'b100, 32'h5555_AAAA, 4'hC, 32'h0, 1'b0);
      xfer(1'b0, 3'b010, 32'h0, 4'h0, 32'h8765_4321, 1'b0);
      idle(5);

      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL leftover_expectations got %0d pending, required 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
